// File: rtl/npc_pkg.sv
// Shared definitions for the npc core: datapath width, reset vector and the
// instruction-fetch state encoding used by ifu_fetch and visible on its
// debug port.
package npc_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        ISSUE = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } ifu_state_e;

    // A fetch target must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit for the single-issue npc core.
// Owns the architectural pc, issues one instruction-memory read per
// instruction, hands the word to decode and waits for execute to commit the
// next pc before fetching again (no prefetch, one request outstanding).
// Optional build macro IFU_MISALIGN_TRAP_EN: a committed next pc with
// bits [1:0] != 0 parks the unit in HALT and raises misalign_fault until rst.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; once valid is raised, the payload (addr or inst/pc) is held
// stable and valid is not withdrawn until that transfer happens.
module ifu_fetch #(
    parameter int               XLEN     = npc_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = npc_pkg::RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_resp_valid,
    input  logic [XLEN-1:0]     imem_resp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [XLEN-1:0]     inst,
    output logic [XLEN-1:0]     pc,
    input  logic                commit_valid,
    input  logic [XLEN-1:0]     commit_next_pc,
    output logic [31:0]         fetch_cnt,
`ifdef IFU_MISALIGN_TRAP_EN
    output logic                misalign_fault,
`endif
    output npc_pkg::ifu_state_e dbg_state
);

    import npc_pkg::*;

    ifu_state_e      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic            r_req_valid;
    logic            r_inst_valid;
    logic [31:0]     r_fetch_cnt;
    logic            w_commit_take;
    logic            w_commit_fault;

    // A commit counts in EXEC, or in ISSUE when decode takes the instruction
    // in the same cycle; everywhere else commit_valid is ignored.
    assign w_commit_take = commit_valid &&
                           ((r_state == EXEC) || ((r_state == ISSUE) && inst_ready));

`ifdef IFU_MISALIGN_TRAP_EN
    logic r_fault;

    assign w_commit_fault = is_misaligned(commit_next_pc[1:0]);
    assign misalign_fault = r_fault;

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_commit_take && w_commit_fault) begin
            r_fault <= 1'b1;
        end
    end
`else
    assign w_commit_fault = 1'b0;
`endif

    // Fetch FSM together with the pc, instruction and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_fetch_cnt  <= 32'd0;
        end else begin
            case (r_state)
                FETCH: begin
                    // Raised the cycle after reset; dropped once accepted.
                    if (r_req_valid && imem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= WAIT;
                    end else begin
                        r_req_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        r_inst       <= imem_resp_data;
                        r_inst_valid <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_fetch_cnt  <= r_fetch_cnt + 32'd1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                end
                HALT: begin
                end
                default: begin
                    r_state     <= FETCH;
                    r_req_valid <= 1'b0;
                end
            endcase

            // An accepted commit overrides the ISSUE->EXEC step above and
            // either restarts fetch at the new pc or parks in HALT.
            if (w_commit_take) begin
                r_pc <= commit_next_pc;
                if (w_commit_fault) begin
                    r_state <= HALT;
                end else begin
                    r_state     <= FETCH;
                    r_req_valid <= 1'b1;
                end
            end
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_addr      = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign pc             = r_pc;
    assign fetch_cnt      = r_fetch_cnt;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised bench for ifu_fetch. The stimulus process plays instruction
// memory, decode and execute, and pushes the expected fetch addresses and
// instructions into queues as it issues commits and responses; the monitor
// process pops and compares whenever the DUT presents a request or an
// instruction, and checks the cycle-level protocol rules.
module tb_ifu_fetch;

    import npc_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_inst_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_next_pc = 32'd0;
    logic [31:0] fetch_cnt;
    ifu_state_e  dbg_state;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc),
        .commit_valid    (commit_valid),
        .commit_next_pc  (commit_next_pc),
        .fetch_cnt       (fetch_cnt),
`ifdef IFU_MISALIGN_TRAP_EN
        .misalign_fault  (misalign_fault),
`endif
        .dbg_state       (dbg_state)
    );

    // ---------------- scoreboard queues ----------------
    logic [31:0] exp_q[$];        // expected fetch addresses, in order
    exp_inst_t   exp_inst_q[$];   // expected instructions handed to decode
    logic [31:0] plan_q[$];       // directed commit targets, used first
    logic [31:0] data_q[$];       // directed memory words, used first

    // ---------------- stimulus-side model state ----------------
    bit          mem_pending = 0;
    int          mem_delay = 0;
    logic [31:0] mem_data = 32'd0;
    bit          accept_pend = 0;
    bit          resp_real = 0;
    bit          in_exec = 0;
    bit          commit_take = 0;
    bit          halted = 0;
    logic [31:0] model_pc = RST_PC;
    logic [31:0] model_cnt = 32'd0;
    int          p_req_ready = 100;
    int          p_inst_ready = 100;
    int          p_commit = 100;
    int          p_spur = 0;
    int          max_delay = 0;
    int          req_stall = 0;
    int          inst_stall = 0;
    int          timeouts = 0;
    bit          done = 0;

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        return {16'h8000, t[15:2], 2'b00};
    endfunction

    task automatic drive_cycle();
        bit hs;
        // Consequences of the edge that just happened.
        if (resp_real) mem_pending = 0;
        if (accept_pend) begin
            mem_pending = 1;
            mem_delay   = $urandom_range(0, max_delay);
            mem_data    = (data_q.size() != 0) ? data_q.pop_front() : $urandom;
            accept_pend = 0;
        end

        // Instruction memory.
        resp_real       = 0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (mem_pending) begin
            if (mem_delay == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_data;
                resp_real       = 1;
                exp_inst_q.push_back('{pc: model_pc, data: mem_data, cnt: model_cnt});
            end else begin
                mem_delay--;
            end
        end else begin
            imem_resp_valid = (int'($urandom_range(0, 99)) < p_spur);
        end

        if (req_stall > 0 && imem_req_valid) begin
            imem_req_ready = 1'b0;
            req_stall--;
        end else begin
            imem_req_ready = (int'($urandom_range(0, 99)) < p_req_ready);
        end
        accept_pend = imem_req_valid && imem_req_ready;

        // Decode and execute.
        commit_next_pc = (plan_q.size() != 0) ? plan_q[0] : rand_target();
        if (inst_stall > 0 && inst_valid) begin
            inst_ready     = 1'b0;
            commit_valid   = 1'b1;
            commit_next_pc = 32'hDEAD_BEE0;
            inst_stall--;
        end else begin
            inst_ready   = (int'($urandom_range(0, 99)) < p_inst_ready);
            commit_valid = (int'($urandom_range(0, 99)) < p_commit);
        end
        hs          = inst_valid && inst_ready;
        commit_take = commit_valid && (hs || in_exec);
        if (hs) begin
            model_cnt = model_cnt + 32'd1;
            in_exec   = 1;
        end
        if (commit_take) begin
            in_exec  = 0;
            model_pc = commit_next_pc;
            if (plan_q.size() != 0) void'(plan_q.pop_front());
`ifdef IFU_MISALIGN_TRAP_EN
            if (commit_next_pc[1:0] != 2'b00) halted = 1;
            else exp_q.push_back(commit_next_pc);
`else
            exp_q.push_back(commit_next_pc);
`endif
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            drive_cycle();
        end
    endtask

    task automatic do_reset(input int n);
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b0;
        commit_valid    = 1'b0;
        mem_pending     = 0;
        accept_pend     = 0;
        resp_real       = 0;
        in_exec         = 0;
        commit_take     = 0;
        halted          = 0;
        model_pc        = RST_PC;
        model_cnt       = 32'd0;
        exp_q.delete();
        exp_inst_q.delete();
        exp_q.push_back(RST_PC);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive_cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit hit;
        plan_q.push_back(32'h8000_0004);
        plan_q.push_back(32'h8000_0100);
`ifndef IFU_MISALIGN_TRAP_EN
        plan_q.push_back(32'h8000_0102);   // loaded unmodified without the trap
`endif
        data_q.push_back(32'h0000_0413);

        do_reset(3);
        run(30);                 // always-ready memory, next-cycle responses

        req_stall = 5;           // memory refuses a request for 5 cycles
        run(25);
        inst_stall = 3;          // decode stalls 3 cycles, junk commit pulses
        run(25);

        p_req_ready  = 60;
        p_inst_ready = 60;
        p_commit     = 50;
        p_spur       = 20;
        max_delay    = 2;
        run(400);

        // Reset while a request is outstanding.
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            run(1);
            hit = mem_pending;
        end
        if (!hit) begin
            timeouts++;
            $display("FAIL wait_for_wait_state: no accepted request within 100 cycles");
        end
        do_reset(2);
        run(150);

`ifdef IFU_MISALIGN_TRAP_EN
        p_req_ready  = 100;
        p_inst_ready = 100;
        p_commit     = 100;
        plan_q.push_back(32'h8000_0102);
        for (int i = 0; i < 200 && !halted; i++) run(1);
        if (!halted) begin
            timeouts++;
            $display("FAIL wait_for_halt: misaligned commit never taken");
        end
        run(20);
`endif
        done = 1;
        repeat (4) @(posedge clk);
        $display("FAIL end_of_test: monitor did not finish");
        $fatal(1);
    end

    // ---------------- monitor / checker ----------------
    int          checks = 0;
    int          errors = 0;
    int          rst_cnt = 0;
    int          after_rst = 0;
    int          hs_count = 0;
    bit          prev_accept = 0;
    bit          prev_req_stall = 0;
    bit          prev_resp = 0;
    bit          prev_hs = 0;
    bit          prev_inst_stall = 0;
    bit          prev_commit = 0;
    bit          halt_seen = 0;
    logic [31:0] prev_addr, prev_inst, prev_pc, prev_commit_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (timeouts != 0) begin
                errors++;
                $display("FAIL timeouts: %0d bounded waits expired", timeouts);
            end
            check("progress_handshakes", 32'(hs_count >= 40), 32'd1);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else if (rst) begin
            rst_cnt++;
            if (rst_cnt == 2) begin
                check("rst_pc", pc, RST_PC);
                check("rst_req_valid", 32'(imem_req_valid), 32'd0);
                check("rst_inst_valid", 32'(inst_valid), 32'd0);
                check("rst_inst", inst, 32'd0);
                check("rst_fetch_cnt", fetch_cnt, 32'd0);
                check("rst_state", 32'(dbg_state), 32'(FETCH));
`ifdef IFU_MISALIGN_TRAP_EN
                check("rst_fault", 32'(misalign_fault), 32'd0);
`endif
            end
            after_rst       = 1;
            prev_accept     = 0;
            prev_req_stall  = 0;
            prev_resp       = 0;
            prev_hs         = 0;
            prev_inst_stall = 0;
            prev_commit     = 0;
            halt_seen       = 0;
        end else begin
            rst_cnt = 0;
            if (after_rst == 1) begin
                check("req_low_first_cycle", 32'(imem_req_valid), 32'd0);
                after_rst = 2;
            end else if (after_rst == 2) begin
                check("req_rise_after_rst", 32'(imem_req_valid), 32'd1);
                after_rst = 0;
            end

            if (prev_accept) check("req_drop_after_accept", 32'(imem_req_valid), 32'd0);
            if (prev_req_stall) begin
                check("req_hold_valid", 32'(imem_req_valid), 32'd1);
                check("req_hold_addr", imem_addr, prev_addr);
            end
            if (prev_resp) check("inst_valid_after_resp", 32'(inst_valid), 32'd1);
            if (prev_hs) check("inst_valid_drop", 32'(inst_valid), 32'd0);
            if (prev_inst_stall) begin
                check("inst_hold_valid", 32'(inst_valid), 32'd1);
                check("inst_hold_inst", inst, prev_inst);
                check("inst_hold_pc", pc, prev_pc);
            end
            if (prev_commit) begin
`ifdef IFU_MISALIGN_TRAP_EN
                if (prev_commit_pc[1:0] != 2'b00) halt_seen = 1;
                else check("req_after_commit", 32'(imem_req_valid), 32'd1);
`else
                check("req_after_commit", 32'(imem_req_valid), 32'd1);
`endif
            end
`ifdef IFU_MISALIGN_TRAP_EN
            if (halt_seen) begin
                check("halt_fault", 32'(misalign_fault), 32'd1);
                check("halt_pc", pc, 32'h8000_0102);
                check("halt_req_valid", 32'(imem_req_valid), 32'd0);
                check("halt_inst_valid", 32'(inst_valid), 32'd0);
            end
`endif

            if (imem_req_valid && imem_req_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_request: addr %h with no fetch expected", imem_addr);
                end else begin
                    check("fetch_addr", imem_addr, exp_q.pop_front());
                end
            end
            if (inst_valid && inst_ready) begin
                if (exp_inst_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: inst %h with no response given", inst);
                end else begin
                    exp_inst_t e;
                    e = exp_inst_q.pop_front();
                    check("issue_inst", inst, e.data);
                    check("issue_pc", pc, e.pc);
                    check("issue_fetch_cnt", fetch_cnt, e.cnt);
                end
                hs_count++;
            end

            prev_accept     = imem_req_valid && imem_req_ready;
            prev_req_stall  = imem_req_valid && !imem_req_ready;
            prev_addr       = imem_addr;
            prev_resp       = resp_real;
            prev_hs         = inst_valid && inst_ready;
            prev_inst_stall = inst_valid && !inst_ready;
            prev_inst       = inst;
            prev_pc         = pc;
            prev_commit     = commit_take;
            prev_commit_pc  = commit_next_pc;
        end
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the single-issue npc core.
- Owns the architectural PC register and issues one instruction-memory read per instruction.
- Hands the fetched instruction and its PC to decode/execute.
- Consumes the next_pc that execute returns at commit, and is the only writer of pc.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, width of PC, address and instruction.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  XLEN  read address, equal to pc.
- imem_resp_valid  input  1  read data valid, one-cycle pulse.
- imem_resp_data  input  XLEN  instruction word.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts the instruction.
- inst  output  XLEN  fetched instruction.
- pc  output  XLEN  PC of inst; drives execute's pc input.
- commit_valid  input  1  execute finished the current instruction.
- commit_next_pc  input  XLEN  next PC from execute (pc+4, pc+imm, or (src1+imm)&~1).
- fetch_cnt  output  32  count of instructions handed to decode.

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, imem_req_valid=0, inst_valid=0, inst=0, fetch_cnt=0.
- imem_req_valid is registered and rises the cycle after rst deasserts.
- States:
  - FETCH: imem_req_valid=1, imem_addr=pc. On imem_req_ready -> WAIT, and req_valid drops the next cycle. Once asserted, req_valid and addr stay stable until ready.
  - WAIT: req_valid=0. On imem_resp_valid, latch imem_resp_data into inst, set inst_valid=1, -> ISSUE.
  - ISSUE: inst_valid=1; inst and pc stay stable until inst_ready. On inst_ready: inst_valid=0 next cycle, fetch_cnt+=1, -> EXEC. If commit_valid is also high in that same cycle, load pc<=commit_next_pc and go directly to FETCH.
  - EXEC: on commit_valid, pc<=commit_next_pc -> FETCH.
- Exactly one outstanding memory request at a time; no prefetch, no speculation.
- pc changes only on an accepted commit (or reset).
- Minimum loop with ready/resp in the next cycle:
  - req issued cycle 0, accepted cycle 0.
  - resp cycle 1, inst_valid cycle 2.
  - handshake plus commit cycle 2, next req cycle 3.
- Ignored events:
  - imem_resp_valid outside WAIT.
  - commit_valid in FETCH/WAIT, and in ISSUE without inst_ready.
  - Same-cycle req_ready and resp_valid while in FETCH: resp ignored, ready honoured.
- fetch_cnt wraps from 32'hFFFF_FFFF to 0.
- Reset mid-operation returns to FETCH with pc=RESET_PC and drops any outstanding request. The memory shares rst, so a stale response cannot arrive.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- With it: a commit whose commit_next_pc[1:0]!=0 moves to a terminal HALT state.
  - Adds output misalign_fault (1 bit, reset 0), set to 1 and held.
  - pc holds the faulting target.
  - imem_req_valid and inst_valid stay 0 until rst.
- Without it: the port does not exist, and pc is loaded with the address unmodified.

Decomposition:
- Shared package npc_pkg holds:
  - RESET_PC_DEFAULT.
  - The ifu_state enum (FETCH, WAIT, ISSUE, EXEC, HALT).
  - The XLEN constant, also used by execute and decode.
- No sub-module: the FSM and PC register are single-purpose and small.

Test Plan:
- Reset then release, memory always ready, resp one cycle later -> first imem_addr=0x8000_0000; inst_valid at cycle 2 with inst=0x00000413; fetch_cnt=1 after handshake.
- Commit with next_pc=0x8000_0004, then 0x8000_0100 (jal) -> subsequent imem_addr values 0x8000_0004 and 0x8000_0100 exactly, one request each.
- imem_req_ready held low 5 cycles -> req_valid and addr stable all 5 cycles; single acceptance; no duplicate request.
- inst_ready low 3 cycles after inst_valid -> inst and pc stable; commit_valid pulsed during the stall ignored; pc unchanged.
- Spurious resp_valid in FETCH, and rst asserted in WAIT -> response ignored; after reset pc=0x8000_0000, fetch_cnt=0, fetch restarts.
- With IFU_MISALIGN_TRAP_EN, commit_next_pc=0x8000_0102 -> misalign_fault=1 next cycle, pc=0x8000_0102, no further requests until rst.
